// File: rtl/fetch_tile_streamer_pkg.sv
// Shared types and constants for the fetch tile streamer: FSM states,
// default geometry and the credit-counter width helper.
package fetch_tile_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_e;

    localparam int DEF_DATA_WIDTH           = 256;
    localparam int DEF_NUM_FETCHES_PER_TILE = 32;

    // The counter must hold the full FIFO_DEPTH value, not just DEPTH-1.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_tile_streamer_fifo.sv
// First-word-fall-through synchronous FIFO. Read data is the current head.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module tile_sync_fifo #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  wr_en;
    logic                  rd_en;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign rd_en    = pop & ~empty;
    assign wr_en    = push & (~full | rd_en);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_tile_streamer.sv
// Sequences N-tile fetch jobs, captures BRAM Port-B read data into a FIFO and
// streams it out with a per-tile last flag; credits keep every tile fetch room.
module fetch_tile_streamer
    import fetch_tile_streamer_pkg::*;
#(
    parameter int NUM_FETCHES_PER_TILE = DEF_NUM_FETCHES_PER_TILE,
    parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH           = 64,
    parameter int READ_LATENCY         = 1,
    parameter int TILE_CNT_WIDTH       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      job_start,
    input  logic [TILE_CNT_WIDTH-1:0] num_tiles,
    output logic                      fetch_start,
    output logic                      fetch_reset_addr,
    input  logic                      bram_en,
    input  logic [DATA_WIDTH-1:0]     bram_dout,
    input  logic                      fetch_done,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic                      m_last,
    output logic                      busy,
    output logic                      job_done,
    output logic                      overflow_err
);
    localparam int CW = credit_w(FIFO_DEPTH);
    localparam int OW = (NUM_FETCHES_PER_TILE > 1) ? $clog2(NUM_FETCHES_PER_TILE) : 1;

    state_e                    state_q, state_d;
    logic [TILE_CNT_WIDTH-1:0] tiles_left_q, tiles_left_d;
    logic [CW-1:0]             credits_q, credits_d;
    logic [READ_LATENCY-1:0]   en_pipe_q, en_pipe_d;
    logic [OW-1:0]             out_cnt_q, out_cnt_d;
    logic                      fetch_start_q, fetch_start_d;
    logic                      fetch_reset_addr_q, fetch_reset_addr_d;
    logic                      job_done_q, job_done_d;
    logic                      busy_q, busy_d;
    logic                      overflow_q, overflow_d;

    logic                      push, pop, in_flight;
    logic                      fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0]     fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign push      = en_pipe_q[READ_LATENCY-1];
    assign in_flight = |en_pipe_q;
    assign pop       = m_valid & m_ready;

    tile_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bram_dout),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_valid          = ~fifo_empty;
    assign m_data           = fifo_empty ? '0 : fifo_head;
    assign m_last           = m_valid & (out_cnt_q == OW'(NUM_FETCHES_PER_TILE - 1));
    assign fetch_start      = fetch_start_q;
    assign fetch_reset_addr = fetch_reset_addr_q;
    assign job_done         = job_done_q;
    assign busy             = busy_q;
    assign overflow_err     = overflow_q;

    // Datapath: read-latency delay line, credits, output word counter, overflow.
    always_comb begin
        en_pipe_d  = (en_pipe_q << 1) | READ_LATENCY'(bram_en);
        credits_d  = credits_q;
        out_cnt_d  = out_cnt_q;
        overflow_d = overflow_q | (push & fifo_full & ~pop);
        if (pop) begin
            credits_d = credits_d + CW'(1);
            out_cnt_d = m_last ? '0 : out_cnt_q + OW'(1);
        end
        if (fetch_start_q) credits_d = credits_d - CW'(NUM_FETCHES_PER_TILE);
    end

    always_comb begin
        state_d            = state_q;
        tiles_left_d       = tiles_left_q;
        fetch_start_d      = 1'b0;
        fetch_reset_addr_d = 1'b0;
        job_done_d         = 1'b0;
        busy_d             = busy_q;
        case (state_q)
            IDLE: begin
                if (job_start) begin
                    tiles_left_d       = num_tiles;
                    fetch_reset_addr_d = 1'b1;
                    busy_d             = 1'b1;
                    state_d            = (num_tiles == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                // The credit decrement lands the cycle the pulse is visible,
                // before WAIT can loop back here.
                if (credits_q >= CW'(NUM_FETCHES_PER_TILE)) begin
                    fetch_start_d = 1'b1;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (fetch_done) begin
                    tiles_left_d = tiles_left_q - 1'b1;
                    state_d      = (tiles_left_q == TILE_CNT_WIDTH'(1)) ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                if (fifo_count == '0 && !in_flight && !push) begin
                    job_done_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            tiles_left_q       <= '0;
            credits_q          <= CW'(FIFO_DEPTH);
            en_pipe_q          <= '0;
            out_cnt_q          <= '0;
            fetch_start_q      <= 1'b0;
            fetch_reset_addr_q <= 1'b0;
            job_done_q         <= 1'b0;
            busy_q             <= 1'b0;
            overflow_q         <= 1'b0;
        end else begin
            state_q            <= state_d;
            tiles_left_q       <= tiles_left_d;
            credits_q          <= credits_d;
            en_pipe_q          <= en_pipe_d;
            out_cnt_q          <= out_cnt_d;
            fetch_start_q      <= fetch_start_d;
            fetch_reset_addr_q <= fetch_reset_addr_d;
            job_done_q         <= job_done_d;
            busy_q             <= busy_d;
            overflow_q         <= overflow_d;
        end
    end

endmodule

// File: tb/tb_fetch_tile_streamer.sv
// Scoreboard bench: a fetch-logic/BRAM model feeds the DUT, expected words are
// queued per job from the BRAM image, and a monitor checks every accepted word.
module tb_fetch_tile_streamer;
    localparam int NF = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_start;
    logic [7:0]    num_tiles;
    logic          fetch_start, fetch_reset_addr;
    logic          bram_en;
    logic [DW-1:0] bram_dout;
    logic          fetch_done;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic          busy, job_done, overflow_err;

    fetch_tile_streamer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .job_start        (job_start),
        .num_tiles        (num_tiles),
        .fetch_start      (fetch_start),
        .fetch_reset_addr (fetch_reset_addr),
        .bram_en          (bram_en),
        .bram_dout        (bram_dout),
        .fetch_done       (fetch_done),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last),
        .busy             (busy),
        .job_done         (job_done),
        .overflow_err     (overflow_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] bmem [512];
    int            nvec = 0, nmis = 0;
    int            mode = 1;          // m_ready policy: 0 low, 1 high, 2 random
    int            js_cnt, fr_cnt, pop_cnt, done_cnt = 0, done_base;
    int            starts_pops[$];

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Fetch logic + BRAM: NF consecutive reads per fetch_start, address kept
    // across tiles and cleared by fetch_reset_addr; data one cycle after en.
    initial begin : fetch_model
        int addr, cnt, prev_addr;
        bit prev_en, done_pend;
        addr = 0; cnt = 0; prev_addr = 0; prev_en = 0; done_pend = 0;
        bram_en = 0; fetch_done = 0; bram_dout = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                addr = 0; cnt = 0; prev_en = 0; done_pend = 0;
                bram_en = 0; fetch_done = 0; bram_dout = rand256();
            end else begin
                bram_dout  = prev_en ? bmem[prev_addr] : rand256();
                fetch_done = done_pend;
                done_pend  = 0;
                if (fetch_reset_addr) addr = 0;
                if (fetch_start) cnt = NF;
                if (cnt > 0) begin
                    bram_en   = 1;
                    prev_addr = addr;
                    addr++;
                    cnt--;
                    if (cnt == 0) done_pend = 1;
                end else begin
                    bram_en = 0;
                end
                prev_en = bram_en;
            end
        end
    end

    initial begin : ready_driver
        m_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_ready = 0;
                1:       m_ready = 1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fetch_start) begin
                    js_cnt++;
                    starts_pops.push_back(pop_cnt);
                    chk("start_vs_reset_addr_overlap", DW'(fetch_reset_addr), DW'(0));
                end
                if (fetch_reset_addr) fr_cnt++;
                if (job_done) done_cnt++;
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_word", DW'(1), DW'(0));
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("data[%0d]", pop_cnt), m_data, e.d);
                        chk($sformatf("last[%0d]", pop_cnt), DW'(m_last), DW'(e.last));
                    end
                    pop_cnt++;
                end
            end
        end
    end

    task automatic start_job(input int n);
        for (int i = 0; i < n * NF; i++) begin
            exp_t e;
            e.d    = bmem[i];
            e.last = ((i % NF) == NF - 1);
            sb.push_back(e);
        end
        js_cnt = 0; fr_cnt = 0; pop_cnt = 0; starts_pops.delete();
        done_base = done_cnt;
        num_tiles = 8'(n);
        job_start = 1;
        step();
        job_start = 0;
        chk("reset_addr_pulse", DW'(fetch_reset_addr), DW'(1));
        chk("busy_on_start", DW'(busy), DW'(1));
    endtask

    task automatic wait_done(input int n, input int bound);
        int c;
        for (c = 0; c < bound; c++) begin
            if (done_cnt != done_base) break;
            step();
        end
        chk("job_done_in_time", DW'(c < bound), DW'(1));
        chk("busy_after_done", DW'(busy), DW'(0));
        repeat (4) step();
        chk("job_done_once", DW'(done_cnt - done_base), DW'(1));
        chk("words_left", DW'(sb.size()), DW'(0));
        chk("reset_addr_count", DW'(fr_cnt), DW'(1));
        chk("fetch_start_count", DW'(js_cnt), DW'(n));
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int c;
        for (int i = 0; i < 512; i++) bmem[i] = rand256();
        rst_n = 0; job_start = 0; num_tiles = '0;
        repeat (3) step();
        chk("rst_m_valid", DW'(m_valid), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_pulses", DW'({fetch_start, fetch_reset_addr, job_done}), DW'(0));
        chk("rst_overflow", DW'(overflow_err), DW'(0));
        rst_n = 1;
        repeat (2) step();

        // Single tile, always ready.
        mode = 1;
        start_job(1);
        step();
        chk("fetch_start_after_reset_addr", DW'(fetch_start), DW'(1));
        wait_done(1, 300);

        // Full backpressure: only two tiles fit, then release.
        mode = 0;
        start_job(4);
        repeat (150) step();
        chk("bp_starts_stalled", DW'(js_cnt), DW'(2));
        chk("bp_valid_held", DW'(m_valid), DW'(1));
        chk("bp_no_overflow", DW'(overflow_err), DW'(0));
        mode = 1;
        wait_done(4, 1000);
        chk("bp_third_start_after_32_pops", DW'(starts_pops.size() > 2 && starts_pops[2] >= NF), DW'(1));

        // Empty job.
        start_job(0);
        chk("empty_no_valid", DW'(m_valid), DW'(0));
        wait_done(0, 3);

        // Random backpressure over three tiles.
        mode = 2;
        start_job(3);
        wait_done(3, 3000);

        // job_start while busy must be ignored.
        start_job(2);
        repeat (5) step();
        num_tiles = 8'd7;
        job_start = 1;
        step();
        job_start = 0;
        wait_done(2, 3000);

        // Reset in the middle of tile 2, then a clean job.
        mode = 1;
        start_job(3);
        for (c = 0; c < 500 && pop_cnt < 40; c++) step();
        chk("reached_tile2", DW'(pop_cnt >= 40), DW'(1));
        rst_n = 0;
        #1;
        chk("midrst_m_valid_last", DW'({m_valid, m_last}), DW'(0));
        chk("midrst_m_data", m_data, DW'(0));
        chk("midrst_pulses", DW'({fetch_start, fetch_reset_addr, job_done}), DW'(0));
        chk("midrst_busy_ovf", DW'({busy, overflow_err}), DW'(0));
        sb.delete();
        repeat (3) step();
        rst_n = 1;
        step();
        start_job(1);
        wait_done(1, 300);

        chk("overflow_final", DW'(overflow_err), DW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
